// File: rtl/merge_pkg.sv
// merge_pkg: shared width default and output-source encodings for the merge stage
package merge_pkg;
  localparam int DATA_W = 32;
  localparam logic SRC_1 = 1'b0;
  localparam logic SRC_2 = 1'b1;
endpackage

// File: rtl/merge_stage_if.sv
// merge_stage_if: source, arbiter and downstream handshake bundle of the merge stage
interface merge_stage_if #(parameter int DATA_W = merge_pkg::DATA_W) ();
  logic              stall;
  logic              in1_valid, in1_ready, in2_valid, in2_ready;
  logic [DATA_W-1:0] in1_data, in2_data, out_data;
  logic              req_1, req_2, grant_1, grant_2;
  logic              out_valid, out_src, out_ready, err;
  modport master (
    output stall, in1_valid, in1_data, in2_valid, in2_data, grant_1, grant_2, out_ready,
    input  in1_ready, in2_ready, req_1, req_2, out_valid, out_data, out_src, err
  );
  modport slave (
    input  stall, in1_valid, in1_data, in2_valid, in2_data, grant_1, grant_2, out_ready,
    output in1_ready, in2_ready, req_1, req_2, out_valid, out_data, out_src, err
  );
endinterface

// File: rtl/merge_hold_slot.sv
// merge_hold_slot: one-entry valid/data buffer; a load wins over a clear in the same cycle
module merge_hold_slot #(parameter int DATA_W = merge_pkg::DATA_W) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/merge_stage.sv
// merge_stage: buffers one item per source, requests the arbiter, forwards the winner
module merge_stage #(parameter int DATA_W = merge_pkg::DATA_W) (
  input logic            clk,
  input logic            reset,
  merge_stage_if.slave   bus
);
  import merge_pkg::*;
  logic              w_hv1, w_hv2, w_slot_free, w_req1, w_req2;
  logic              w_fire1, w_fire2, w_rdy1, w_rdy2, w_acc1, w_acc2, w_clash;
  logic [DATA_W-1:0] w_hd1, w_hd2;
  logic              r_out_valid, r_out_src, r_err;
  logic [DATA_W-1:0] r_out_data;
  assign w_slot_free = ~bus.stall & (~r_out_valid | bus.out_ready);
  assign w_req1  = w_hv1 & w_slot_free;
  assign w_req2  = w_hv2 & w_slot_free;
  // a double grant is a protocol error: source 1 wins and source 2 keeps its item
  assign w_clash = bus.grant_1 & bus.grant_2 & w_req1 & w_req2;
  assign w_fire1 = bus.grant_1 & w_req1;
  assign w_fire2 = bus.grant_2 & w_req2 & ~w_fire1;
  assign w_rdy1  = ~bus.stall & (~w_hv1 | w_fire1);
  assign w_rdy2  = ~bus.stall & (~w_hv2 | w_fire2);
  assign w_acc1  = bus.in1_valid & w_rdy1;
  assign w_acc2  = bus.in2_valid & w_rdy2;
  merge_hold_slot #(.DATA_W(DATA_W)) u_hold1 (
    .clk(clk), .reset(reset), .i_load(w_acc1), .i_clear(w_fire1),
    .i_data(bus.in1_data), .o_valid(w_hv1), .o_data(w_hd1)
  );
  merge_hold_slot #(.DATA_W(DATA_W)) u_hold2 (
    .clk(clk), .reset(reset), .i_load(w_acc2), .i_clear(w_fire2),
    .i_data(bus.in2_data), .o_valid(w_hv2), .o_data(w_hd2)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= SRC_1;
      r_err       <= 1'b0;
    end else if (~bus.stall) begin
      if (w_fire1 | w_fire2) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_fire1 ? w_hd1 : w_hd2;
        r_out_src   <= w_fire1 ? SRC_1 : SRC_2;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_clash) r_err <= 1'b1;
    end
  assign bus.req_1     = w_req1;
  assign bus.req_2     = w_req2;
  assign bus.in1_ready = w_rdy1;
  assign bus.in2_ready = w_rdy2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_merge_stage.sv
// tb_merge_stage: directed vector table plus hand-written reset sequences around an alternating arbiter
module tb_merge_stage;
  logic clk = 1'b0;
  logic reset;
  logic force_both;
  logic r_pri;
  int checks = 0;
  int errors = 0;
  merge_stage_if bus ();
  merge_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // alternating-priority arbiter: whoever was just granted loses the next tie
  always_comb begin
    bus.grant_1 = force_both | (bus.req_1 & (~bus.req_2 | ~r_pri));
    bus.grant_2 = force_both | (bus.req_2 & (~bus.req_1 | r_pri));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pri <= 1'b0;
    else if (~force_both & bus.grant_1 & bus.req_1) r_pri <= 1'b1;
    else if (~force_both & bus.grant_2 & bus.req_2) r_pri <= 1'b0;
  typedef struct {
    logic stall, frc, v1, v2, ordy;
    logic [31:0] d1, d2;
    logic [3:0] comb;
    logic ov, os, er;
    logic [31:0] od;
  } vec_t;
  vec_t vt[25];
  function automatic vec_t mk(input logic stall, frc, v1, input logic [31:0] d1,
                              input logic v2, input logic [31:0] d2, input logic ordy,
                              input logic [3:0] comb, input logic ov, input logic [31:0] od,
                              input logic os, er);
    vec_t v;
    v.stall = stall; v.frc = frc; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2;
    v.ordy = ordy; v.comb = comb; v.ov = ov; v.od = od; v.os = os; v.er = er;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic stall, frc, v1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] d2, input logic ordy);
    bus.stall = stall; force_both = frc;
    bus.in1_valid = v1; bus.in1_data = d1;
    bus.in2_valid = v2; bus.in2_data = d2;
    bus.out_ready = ordy;
  endtask
  task automatic step(input int i);
    vec_t v;
    v = vt[i];
    drive(v.stall, v.frc, v.v1, v.d1, v.v2, v.d2, v.ordy);
    #1;
    chk($sformatf("comb[%0d] req1,req2,rdy1,rdy2", i),
        {60'd0, bus.req_1, bus.req_2, bus.in1_ready, bus.in2_ready}, {60'd0, v.comb});
    @(posedge clk); #1;
    chk($sformatf("out[%0d] valid,src,err,data", i),
        {29'd0, bus.out_valid, bus.out_src, bus.err, bus.out_data}, {29'd0, v.ov, v.os, v.er, v.od});
  endtask
  initial begin
    // single source
    vt[0]  = mk(0,0,1,32'hA1,0,0,1,4'b0011,0,32'h00,0,0);
    vt[1]  = mk(0,0,1,32'hA2,0,0,1,4'b1011,1,32'hA1,0,0);
    vt[2]  = mk(0,0,1,32'hA3,0,0,1,4'b1011,1,32'hA2,0,0);
    vt[3]  = mk(0,0,0,32'h00,0,0,1,4'b1011,1,32'hA3,0,0);
    vt[4]  = mk(0,0,0,32'h00,0,0,1,4'b0011,0,32'hA3,0,0);
    // contention, both sources saturated, arbiter freshly reset
    vt[5]  = mk(0,0,1,32'h11,1,32'h21,1,4'b0011,0,32'h00,0,0);
    vt[6]  = mk(0,0,1,32'h12,1,32'h22,1,4'b1110,1,32'h11,0,0);
    vt[7]  = mk(0,0,1,32'h13,1,32'h22,1,4'b1101,1,32'h21,1,0);
    vt[8]  = mk(0,0,1,32'h13,1,32'h23,1,4'b1110,1,32'h12,0,0);
    vt[9]  = mk(0,0,1,32'h14,1,32'h23,1,4'b1101,1,32'h22,1,0);
    vt[10] = mk(0,0,1,32'h14,1,32'h24,1,4'b1110,1,32'h13,0,0);
    // downstream backpressure for three cycles, then drain
    vt[11] = mk(0,0,1,32'h15,1,32'h24,0,4'b0000,1,32'h13,0,0);
    vt[12] = mk(0,0,1,32'h15,1,32'h24,0,4'b0000,1,32'h13,0,0);
    vt[13] = mk(0,0,1,32'h15,1,32'h24,0,4'b0000,1,32'h13,0,0);
    vt[14] = mk(0,0,1,32'h15,1,32'h24,1,4'b1101,1,32'h23,1,0);
    vt[15] = mk(0,0,1,32'h15,1,32'h25,1,4'b1110,1,32'h14,0,0);
    // global stall for four cycles with out_ready high
    vt[16] = mk(1,0,1,32'h16,1,32'h25,1,4'b0000,1,32'h14,0,0);
    vt[17] = mk(1,0,1,32'h16,1,32'h25,1,4'b0000,1,32'h14,0,0);
    vt[18] = mk(1,0,1,32'h16,1,32'h25,1,4'b0000,1,32'h14,0,0);
    vt[19] = mk(1,0,1,32'h16,1,32'h25,1,4'b0000,1,32'h14,0,0);
    vt[20] = mk(0,0,1,32'h16,1,32'h25,1,4'b1101,1,32'h24,1,0);
    vt[21] = mk(0,0,1,32'h16,1,32'h26,1,4'b1110,1,32'h15,0,0);
    // double grant, then recovery, then grants with no requests
    vt[22] = mk(0,1,0,32'h00,0,32'h00,1,4'b1110,1,32'h16,0,1);
    vt[23] = mk(0,0,0,32'h00,0,32'h00,1,4'b0111,1,32'h25,1,1);
    vt[24] = mk(0,1,0,32'h00,0,32'h00,1,4'b0011,0,32'h25,1,1);
    reset = 1'b1;
    drive(0,0,0,0,0,0,0);
    #2;
    chk("reset out valid,src,err,data", {29'd0, bus.out_valid, bus.out_src, bus.err, bus.out_data}, 64'd0);
    chk("reset req", {62'd0, bus.req_1, bus.req_2}, 64'd0);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step(i);
    // load hold 1 and the output slot, then reset asynchronously mid-cycle
    drive(0,0,1,32'h31,0,0,1);
    @(posedge clk); #1;
    drive(0,0,1,32'h32,0,0,0);
    @(posedge clk); #1;
    chk("preload out valid,data", {31'd0, bus.out_valid, bus.out_data}, {31'd0, 1'b1, 32'h31});
    reset = 1'b1;
    #1;
    chk("midreset out valid,src,err,data", {29'd0, bus.out_valid, bus.out_src, bus.err, bus.out_data}, 64'd0);
    chk("midreset req", {62'd0, bus.req_1, bus.req_2}, 64'd0);
    drive(0,0,0,0,0,0,1);
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle[%0d] out valid,data", i), {31'd0, bus.out_valid, bus.out_data}, 64'd0);
      chk($sformatf("idle[%0d] req", i), {62'd0, bus.req_1, bus.req_2}, 64'd0);
    end
    for (int i = 5; i < 25; i++) step(i);
    reset = 1'b1;
    #1;
    chk("err cleared by reset", {63'd0, bus.err}, 64'd0);
    #2 reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/merge_stage.md
Name: merge_stage

Overview:
- Two-source merge stage sitting directly upstream of the two-requester alternating-priority arbiter.
- Buffers one item per source, raises req_1/req_2 toward the arbiter and consumes grant_1/grant_2 in the same cycle.
- Forwards the granted item into a single registered output slot for the shared downstream pipeline stage.
- Honours the pipeline-wide global stall: while stall is high, nothing moves.

Parameters:
- DATA_W, 32, payload width of each input and of the output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  global pipeline stall; freezes all state.
- in1_valid  input  1  source 1 offers in1_data.
- in1_data  input  DATA_W  source 1 payload.
- in1_ready  output  1  source 1 transfer accepted this cycle when in1_valid is also high.
- in2_valid  input  1  source 2 offers in2_data.
- in2_data  input  DATA_W  source 2 payload.
- in2_ready  output  1  source 2 accept, same rule as in1_ready.
- req_1  output  1  request to arbiter for source 1.
- req_2  output  1  request to arbiter for source 2.
- grant_1  input  1  combinational grant from arbiter for source 1.
- grant_2  input  1  combinational grant from arbiter for source 2.
- out_valid  output  1  output slot holds a valid item.
- out_data  output  DATA_W  forwarded payload.
- out_src  output  1  origin of out_data: 0 = source 1, 1 = source 2.
- out_ready  input  1  downstream consumes out_data when out_valid is high.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous: hold_v1=hold_v2=0, hold_d*=0, out_valid=0, out_data=0, out_src=0, err=0. Deassertion mid-operation discards all buffered items; no partial transfers.
- slot_free = ~stall & (~out_valid | out_ready).
- req_n = hold_vn & slot_free. Combinational, no dependence on in*_valid, so there are no loops.
- fire_n = grant_n & req_n. A grant without a matching request is ignored.
- If grant_1 and grant_2 are high in the same cycle while both requests are high:
  - only fire_1 takes effect;
  - err is set to 1 and stays set until reset.
- in_ready_n = ~stall & (~hold_vn | fire_n).
- Hold slot n, when not stalled:
  - accept (in_valid_n & in_ready_n) loads hold_dn and sets hold_vn=1, including the same cycle hold n fires;
  - fire without accept clears hold_vn;
  - otherwise it holds.
- Output slot, when not stalled:
  - fire_n loads out_data=hold_dn, out_src=n-1, out_valid=1;
  - else if out_valid & out_ready, out_valid=0.
- While stall=1:
  - no register changes;
  - req_*=0 and in*_ready=0;
  - out_valid/out_data are held, and out_ready is ignored (no consumption).
- Latency: an item accepted at edge t requests in the cycle after edge t and appears on out_valid after edge t+1, so 2 cycles from accept to output.
- Throughput:
  - 1 item/cycle aggregate.
  - With both sources saturated, output alternates sources following the arbiter's cycle-by-cycle priority, 1 item per source per 2 cycles.
- Ordering: per-source order is preserved, because depth 1 per source cannot reorder.

Decomposition:
- Package merge_pkg holds:
  - DATA_W default;
  - SRC_1=1'b0 and SRC_2=1'b1 encodings for out_src.
- Sub-module merge_hold_slot: one-entry valid/data register with load/clear controls, instantiated twice.
- The arbiter is instantiated beside this block at top level, not inside it.

Test Plan:
- Reset and idle: assert reset mid-stream with hold_v1=1 and out_valid=1. Required response:
  - out_valid=0, out_data=0, err=0, req_*=0 immediately;
  - after release with no valid inputs, outputs stay 0.
- Single source: in1 sends 0xA1, 0xA2, 0xA3 on consecutive cycles with out_ready=1. Required response:
  - out_data=0xA1, 0xA2, 0xA3 on consecutive cycles starting 2 cycles after the first accept;
  - out_src=0 for all three.
- Contention with the real arbiter: both sources continuous (0x1n, 0x2n), out_ready=1, arbiter reset together. Required response:
  - out_src alternates 0,1,0,1 on consecutive cycles;
  - per-source sequence is intact;
  - no item is lost.
- Backpressure: out_ready=0 for 3 cycles with both holds full. Required response:
  - out_valid and out_data are stable;
  - req_*=0 and in*_ready=0;
  - on out_ready=1, draining resumes with no duplicate.
- Global stall: stall=1 for 4 cycles mid-stream with out_ready=1. Required response:
  - all outputs frozen, nothing consumed;
  - after stall drops, the stream continues exactly where it stopped.
- Protocol error: force grant_1=grant_2=1 with both requests high. Required response:
  - source 1 item is forwarded, source 2 is retained;
  - err=1 and stays 1 until reset.
